// File: rtl/timer_text_writer_if.sv
// Character RAM write port A: address, ASCII data and a one-cycle write strobe.
interface timer_text_writer_if;
    logic [12:0] charRamAddrA;
    logic [6:0]  charRamDataA;
    logic        charRamWeA;

    modport master (output charRamAddrA, output charRamDataA, output charRamWeA);
    modport slave  (input  charRamAddrA, input  charRamDataA, input  charRamWeA);
endinterface

// File: rtl/timer_text_writer.sv
// BCD mm:ss game timer; once per frame, writes "MM:SS" into char RAM via port A.
module timer_text_writer #(
    parameter logic [12:0] BASE_ADDR = 13'd36
) (
    input  logic                        clock25MHz,
    input  logic                        resetN,
    input  logic                        tick,
    input  logic                        runEn,
    input  logic                        clear,
    input  logic                        frameStart,
    timer_text_writer_if.master         ramA,
    output logic                        busy,
    output logic                        timeMaxed
);

    typedef enum logic {IDLE, WRITE} stateT;

    stateT      state;
    logic [3:0] mT, mO, sT, sO;
    logic [3:0] shMT, shMO, shST, shSO;
    logic [2:0] idx;
    logic [2:0] nxtIdx;
    logic       advance;

    assign timeMaxed = (mT == 4'd9) && (mO == 4'd9) && (sT == 4'd5) && (sO == 4'd9);
    assign advance   = tick & runEn & ~timeMaxed;
    assign nxtIdx    = idx + 3'd1;

    function automatic logic [6:0] glyph(input logic [2:0] i, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] c,
                                         input logic [3:0] d);
        case (i)
            3'd0:    glyph = 7'h30 + {3'b000, a};
            3'd1:    glyph = 7'h30 + {3'b000, b};
            3'd3:    glyph = 7'h30 + {3'b000, c};
            3'd4:    glyph = 7'h30 + {3'b000, d};
            default: glyph = 7'h3A;
        endcase
    endfunction

    // Carry chain; 99:59 is excluded by advance, so mT never needs to wrap.
    always_ff @(posedge clock25MHz or negedge resetN) begin
        if (!resetN) begin
            mT <= '0; mO <= '0; sT <= '0; sO <= '0;
        end else if (clear) begin
            mT <= '0; mO <= '0; sT <= '0; sO <= '0;
        end else if (advance) begin
            if (sO == 4'd9) begin
                sO <= '0;
                if (sT == 4'd5) begin
                    sT <= '0;
                    if (mO == 4'd9) begin
                        mO <= '0;
                        mT <= mT + 4'd1;
                    end else begin
                        mO <= mO + 4'd1;
                    end
                end else begin
                    sT <= sT + 4'd1;
                end
            end else begin
                sO <= sO + 4'd1;
            end
        end
    end

    // idx names the character currently presented on port A.
    always_ff @(posedge clock25MHz or negedge resetN) begin
        if (!resetN) begin
            state             <= IDLE;
            idx               <= '0;
            shMT <= '0; shMO <= '0; shST <= '0; shSO <= '0;
            ramA.charRamAddrA <= '0;
            ramA.charRamDataA <= '0;
            ramA.charRamWeA   <= 1'b0;
            busy              <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ramA.charRamWeA <= 1'b0;
                    if (frameStart) begin
                        state             <= WRITE;
                        shMT <= mT; shMO <= mO; shST <= sT; shSO <= sO;
                        idx               <= '0;
                        busy              <= 1'b1;
                        ramA.charRamWeA   <= 1'b1;
                        ramA.charRamAddrA <= BASE_ADDR;
                        ramA.charRamDataA <= glyph(3'd0, mT, mO, sT, sO);
                    end
                end
                WRITE: begin
                    if (idx == 3'd4) begin
                        state           <= IDLE;
                        ramA.charRamWeA <= 1'b0;
                        busy            <= 1'b0;
                    end else begin
                        idx               <= nxtIdx;
                        ramA.charRamAddrA <= BASE_ADDR + {10'd0, nxtIdx};
                        ramA.charRamDataA <= glyph(nxtIdx, shMT, shMO, shST, shSO);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
